arm_pipelined_prefetch_unit: RTL

Parametrised successor to the single-register fetch stage of the pipelined ARM datapath. It decouples instruction memory from decode through a depth-configurable prefetch queue and keeps several requests in flight on a valid/ready request channel with in-order responses. Branch and writeback PC redirects flush the queue, and any stale in-flight responses are discarded. Sits between instruction memory and the decode stage; it replaces the PC register, PC+4 adder and instruction register.

---
 rtl/arm_pipelined_pkg.sv | 17 +
 rtl/arm_pipelined_sync_fifo.sv | 68 ++++++
 rtl/arm_pipelined_prefetch_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/arm_pipelined_pkg.sv
// Shared types and constants for the pipelined ARM fetch path.
package arm_pipelined_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Sequential fetch stride and the architectural R15 read-ahead.
  localparam int unsigned PC_INCREMENT = 4;
  localparam int unsigned R15_OFFSET = 8;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [DEFAULT_BUS_WIDTH-1:0] instr;
    logic [DEFAULT_BUS_WIDTH-1:0] pc;
  } prefetch_entry_t;

endpackage

// File: rtl/arm_pipelined_sync_fifo.sv
// Single-clock FIFO of generic entries with a synchronous clear.
// Clear wins over push and pop. Push and pop together leave the count
// unchanged, including when full (the head is read before it is overwritten).
module arm_pipelined_sync_fifo
  import arm_pipelined_pkg::*;
#(
  parameter type         entry_t = prefetch_entry_t,
  parameter int unsigned Depth   = 4,
  localparam int unsigned PtrW   = $clog2(Depth),
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  entry_t          push_data_i,
  input  logic            pop_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  // Pointer and occupancy update; pointers wrap naturally (Depth is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/arm_pipelined_prefetch_unit.sv
// Prefetching fetch stage: keeps up to QueueDepth requests in flight and
// buffers in-order responses for decode. A redirect flushes the queue and
// marks every outstanding response as stale so it is discarded on arrival.
//
// Request channel: a request transfers on a cycle where o_Req_Valid and
// i_Req_Ready are both high; while valid is high and ready low, o_Req_Addr
// holds. Responses arrive in request order and are always accepted.
module arm_pipelined_prefetch_unit
  import arm_pipelined_pkg::*;
#(
  parameter int unsigned          BusWidth    = DEFAULT_BUS_WIDTH,
  parameter int unsigned          QueueDepth  = 4,
  parameter logic [BusWidth-1:0]  ResetVector = BusWidth'(DEFAULT_RESET_VECTOR),
  localparam int unsigned         CntW        = $clog2(QueueDepth + 1)
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic                i_Redirect,
  input  logic [BusWidth-1:0] i_Redirect_PC,
  output logic                o_Req_Valid,
  output logic [BusWidth-1:0] o_Req_Addr,
  input  logic                i_Req_Ready,
  input  logic                i_Rsp_Valid,
  input  logic [BusWidth-1:0] i_Rsp_Instr,
  output logic                o_Instr_Valid,
  output logic [BusWidth-1:0] o_Instr,
  output logic [BusWidth-1:0] o_Instr_PC,
  output logic [BusWidth-1:0] o_Instr_PC_Plus8,
  input  logic                i_Stall_Decode,
  output logic [CntW-1:0]     o_Queue_Count
);

  typedef struct packed {
    logic [BusWidth-1:0] instr;
    logic [BusWidth-1:0] pc;
  } entry_t;

  localparam logic [BusWidth-1:0] PcInc  = BusWidth'(PC_INCREMENT);
  localparam logic [BusWidth-1:0] R15Off = BusWidth'(R15_OFFSET);

  logic [BusWidth-1:0] fetch_pc_q, fetch_pc_d;
  logic [BusWidth-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     drop_q, drop_d;
  logic                req_en_q;

  logic [CntW-1:0]     fifo_count;
  logic [CntW:0]       committed;
  logic [BusWidth-1:0] target_pc;
  logic                req_fire, rsp_push, pop;
  entry_t              push_entry, head;
  logic                redirect_lsb_unused;

  // Word-aligned redirect target; the low two bits are ignored.
  assign target_pc           = {i_Redirect_PC[BusWidth-1:2], 2'b00};
  assign redirect_lsb_unused = ^i_Redirect_PC[1:0];

  // In-flight requests already own a queue slot, so the queue cannot overflow.
  assign committed   = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign o_Req_Valid = req_en_q && !i_Redirect && (committed < (CntW+1)'(QueueDepth));
  assign o_Req_Addr  = fetch_pc_q;
  assign req_fire    = o_Req_Valid && i_Req_Ready;

  assign rsp_push         = i_Rsp_Valid && (drop_q == '0) && !i_Redirect;
  assign push_entry.instr = i_Rsp_Instr;
  assign push_entry.pc    = rsp_pc_q;

  assign o_Instr_Valid    = (fifo_count != '0);
  assign pop              = o_Instr_Valid && !i_Stall_Decode && !i_Redirect;
  assign o_Instr          = o_Instr_Valid ? head.instr : '0;
  assign o_Instr_PC       = o_Instr_Valid ? head.pc : '0;
  assign o_Instr_PC_Plus8 = o_Instr_PC + R15Off;
  assign o_Queue_Count    = fifo_count;

  // Next PCs, outstanding-request count and stale-response budget.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(i_Rsp_Valid);
    if (i_Redirect) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_d     = inflight_q - CntW'(i_Rsp_Valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PcInc;
      if (rsp_push) rsp_pc_d = rsp_pc_q + PcInc;
      if (i_Rsp_Valid && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    end
  end

  // State registers; requests are held off until the first cycle out of reset.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      fetch_pc_q <= ResetVector;
      rsp_pc_q   <= ResetVector;
      inflight_q <= '0;
      drop_q     <= '0;
      req_en_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      req_en_q   <= 1'b1;
    end
  end

  arm_pipelined_sync_fifo #(
    .entry_t (entry_t),
    .Depth   (QueueDepth)
  ) u_queue (
    .clk_i       (i_CLK),
    .rst_ni      (i_NRESET),
    .clear_i     (i_Redirect),
    .push_i      (rsp_push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // Memory must never answer a request that was not made.
  a_no_orphan_rsp: assert property (@(posedge i_CLK) disable iff (!i_NRESET)
    !(i_Rsp_Valid && (inflight_q == '0)));

  // A pending request keeps its address until accepted or redirected.
  a_addr_stable: assert property (@(posedge i_CLK) disable iff (!i_NRESET)
    (o_Req_Valid && !i_Req_Ready && !i_Redirect) |=> $stable(o_Req_Addr));

endmodule
